// File: rtl/base_aburp_src.sv
// base_aburp_src: circular-buffer source for a burp-buffered receiver; o_v is gated by a registered copy of early ready o_r
module base_aburp_src #(
  parameter int width = 1,
  parameter int depth = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    i_v,
  output logic                    i_r,
  input  logic [0:width-1]        i_d,
  output logic                    o_v,
  input  logic                    o_r,
  output logic [0:width-1]        o_d,
  output logic [0:$clog2(depth)]  count
);
  localparam int aw = $clog2(depth);
  logic [0:width-1] mem [depth];
  logic [aw-1:0]    wr_ptr, rd_ptr;
  logic             o_r_q, push, pop;
  assign i_r  = count < (aw+1)'(depth);
  assign o_v  = (|count) & o_r_q;
  assign o_d  = mem[rd_ptr];
  assign push = i_v & i_r;
  assign pop  = o_v;
  always_ff @(posedge clk)
    if (push) mem[wr_ptr] <= i_d;
  // pointers wrap naturally because depth is a power of two
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      o_r_q  <= 1'b0;
    end else begin
      wr_ptr <= wr_ptr + aw'(push);
      rd_ptr <= rd_ptr + aw'(pop);
      count  <= count + (aw+1)'(push) - (aw+1)'(pop);
      o_r_q  <= o_r;
    end
endmodule

// File: tb/tb_base_aburp_src.sv
// tb_base_aburp_src: directed vector table plus hand sequences for stall, wrap and async reset
module tb_base_aburp_src;
  logic       clk, reset, i_v, i_r, o_v, o_r;
  logic [0:7] i_d, o_d;
  logic [0:2] count;
  int n_chk = 0, n_fail = 0;

  base_aburp_src #(.width(8), .depth(4)) dut (
    .clk(clk), .reset(reset), .i_v(i_v), .i_r(i_r), .i_d(i_d),
    .o_v(o_v), .o_r(o_r), .o_d(o_d), .count(count)
  );

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic       iv;
    logic [7:0] d;
    logic       orr;
    logic       ir;
    logic       ov;
    logic [7:0] od;
    int         cnt;
  } vec_t;
  vec_t tbl[17];

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic iv, input logic [7:0] d, input logic orr);
    i_v = iv;
    i_d = d;
    o_r = orr;
    #1;
  endtask

  task automatic tick;
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    reset = 0; i_v = 0; i_d = 0; o_r = 0;
    // in-order pass-through, then fill to full with o_r low, then drain
    tbl[0]  = '{1'b1, 8'h01, 1'b1, 1'b1, 1'b0, 8'h00, 0};
    tbl[1]  = '{1'b1, 8'h02, 1'b1, 1'b1, 1'b1, 8'h01, 1};
    tbl[2]  = '{1'b1, 8'h03, 1'b1, 1'b1, 1'b1, 8'h02, 1};
    tbl[3]  = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 8'h03, 1};
    tbl[4]  = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 8'h00, 0};
    tbl[5]  = '{1'b1, 8'h10, 1'b0, 1'b1, 1'b0, 8'h00, 0};
    tbl[6]  = '{1'b1, 8'h11, 1'b0, 1'b1, 1'b0, 8'h00, 1};
    tbl[7]  = '{1'b1, 8'h12, 1'b0, 1'b1, 1'b0, 8'h00, 2};
    tbl[8]  = '{1'b1, 8'h13, 1'b0, 1'b1, 1'b0, 8'h00, 3};
    tbl[9]  = '{1'b1, 8'h14, 1'b0, 1'b0, 1'b0, 8'h00, 4};
    tbl[10] = '{1'b1, 8'h14, 1'b1, 1'b0, 1'b0, 8'h00, 4};
    tbl[11] = '{1'b1, 8'h14, 1'b1, 1'b0, 1'b1, 8'h10, 4};
    tbl[12] = '{1'b1, 8'h14, 1'b1, 1'b1, 1'b1, 8'h11, 3};
    tbl[13] = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 8'h12, 3};
    tbl[14] = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 8'h13, 2};
    tbl[15] = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 8'h14, 1};
    tbl[16] = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 8'h00, 0};
    #2;
    chk("reset count", int'(count), 0);
    chk("reset i_r", int'(i_r), 1);
    chk("reset o_v", int'(o_v), 0);
    @(negedge clk);
    reset = 1;
    for (int i = 0; i < 17; i++) begin
      drive(tbl[i].iv, tbl[i].d, tbl[i].orr);
      chk($sformatf("tbl%0d i_r", i), int'(i_r), int'(tbl[i].ir));
      chk($sformatf("tbl%0d o_v", i), int'(o_v), int'(tbl[i].ov));
      chk($sformatf("tbl%0d count", i), int'(count), tbl[i].cnt);
      if (tbl[i].ov) chk($sformatf("tbl%0d o_d", i), int'(o_d), int'(tbl[i].od));
      tick;
    end
    // o_r falls with 3 beats buffered: one beat at t, none at t+1
    drive(1, 8'h21, 0); tick;
    drive(1, 8'h22, 0); tick;
    drive(1, 8'h23, 0); tick;
    drive(0, 8'h00, 1);
    chk("stall pre o_v", int'(o_v), 0);
    chk("stall pre count", int'(count), 3);
    tick;
    drive(0, 8'h00, 0);
    chk("stall t o_v", int'(o_v), 1);
    chk("stall t o_d", int'(o_d), 'h21);
    tick;
    chk("stall t+1 o_v", int'(o_v), 0);
    chk("stall t+1 count", int'(count), 2);
    tick;
    drive(0, 8'h00, 1);
    chk("stall rearm o_v", int'(o_v), 0);
    tick;
    chk("stall b2 o_v", int'(o_v), 1);
    chk("stall b2 o_d", int'(o_d), 'h22);
    tick;
    chk("stall b3 o_v", int'(o_v), 1);
    chk("stall b3 o_d", int'(o_d), 'h23);
    tick;
    chk("stall end o_v", int'(o_v), 0);
    chk("stall end count", int'(count), 0);
    // steady push/pop at occupancy 2 across pointer wrap
    drive(1, 8'h40, 0); tick;
    drive(1, 8'h41, 1);
    chk("wrap prime o_v", int'(o_v), 0);
    tick;
    for (int j = 0; j < 20; j++) begin
      drive(1, 8'(8'h42 + j), 1);
      chk($sformatf("wrap%0d count", j), int'(count), 2);
      chk($sformatf("wrap%0d o_v", j), int'(o_v), 1);
      chk($sformatf("wrap%0d o_d", j), int'(o_d), 'h40 + j);
      tick;
    end
    drive(0, 8'h00, 1);
    chk("wrap tail1 o_d", int'(o_d), 'h54);
    tick;
    chk("wrap tail2 o_d", int'(o_d), 'h55);
    tick;
    chk("wrap end count", int'(count), 0);
    chk("wrap end o_v", int'(o_v), 0);
    // async reset between edges with 3 beats buffered
    drive(1, 8'h61, 0); tick;
    drive(1, 8'h62, 0); tick;
    drive(1, 8'h63, 0); tick;
    drive(0, 8'h00, 0);
    chk("arst pre count", int'(count), 3);
    #1 reset = 0;
    #1;
    chk("arst count", int'(count), 0);
    chk("arst i_r", int'(i_r), 1);
    chk("arst o_v", int'(o_v), 0);
    #1 reset = 1;
    tick;
    drive(1, 8'h77, 1);
    chk("post rst o_v", int'(o_v), 0);
    tick;
    drive(0, 8'h00, 1);
    chk("post rst first o_v", int'(o_v), 1);
    chk("post rst first o_d", int'(o_d), 'h77);
    chk("post rst count", int'(count), 1);
    tick;
    chk("post rst drained", int'(count), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
